// File: rtl/timer_pkg.sv
// Shared encodings for the stopwatch/timer sequencing logic.
// Also provides the per-mode counter setup derived from mode and preset digits.
package timer_pkg;

  typedef enum logic [1:0] {
    MODE_UP0  = 2'd0,
    MODE_DN99 = 2'd1,
    MODE_UPP  = 2'd2,
    MODE_DNP  = 2'd3
  } timer_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } timer_state_e;

  localparam logic [15:0] TERM_UP = 16'h9999;
  localparam logic [15:0] TERM_DN = 16'h0000;

  typedef struct packed {
    logic        up;
    logic [15:0] load_value;
  } mode_cfg_t;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic mode_cfg_t mode_cfg(input logic [1:0] m,
                                         input logic [3:0] tens,
                                         input logic [3:0] ones);
    mode_cfg_t c;
    c.up = (m == MODE_UP0) || (m == MODE_UPP);
    case (m)
      MODE_UP0:  c.load_value = 16'h0000;
      MODE_DN99: c.load_value = 16'h9999;
      default:   c.load_value = {clamp_digit(tens), clamp_digit(ones), 8'h00};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioning: 2-FF synchroniser, stable-run debounce, and a
// one-cycle pulse on the debounced rising edge.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2;
  logic          level, level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      press   <= level & ~level_q;
      // Any sample agreeing with the current level restarts the run.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Stopwatch/timer sequencer: button path, run/pause/done FSM, centisecond
// prescaler and the mode-dependent load value / direction for the BCD counter.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startstop,
  input  logic [1:0]  mode,
  input  logic [3:0]  preset_tens,
  input  logic [3:0]  preset_ones,
  input  logic [15:0] count_bcd,
  output logic        load,
  output logic [15:0] load_value,
  output logic        count_en,
  output logic        count_up,
  output logic        running,
  output logic        done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  timer_state_e  state, state_nxt;
  logic [PW-1:0] presc;
  logic          press;
  logic          load_hold;
  logic          at_term;
  mode_cfg_t     cfg_q;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (clk),
    .reset (reset),
    .btn   (startstop),
    .press (press)
  );

  assign load_value = cfg_q.load_value;
  assign count_up   = cfg_q.up;
  assign at_term    = (count_bcd == (cfg_q.up ? TERM_UP : TERM_DN));
  assign count_en   = (state == ST_RUN) && (presc == PW'(TICK_DIV - 1)) && !at_term;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (press) state_nxt = at_term ? ST_DONE : ST_RUN;
      ST_RUN: begin
        // Reaching the terminal value beats a simultaneous pause request.
        if (at_term)    state_nxt = ST_DONE;
        else if (press) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: if (press) state_nxt = at_term ? ST_DONE : ST_RUN;
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      presc     <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      load      <= 1'b1;
      load_hold <= 1'b1;
      cfg_q     <= mode_cfg(mode, preset_tens, preset_ones);
    end else begin
      state     <= state_nxt;
      running   <= (state_nxt == ST_RUN);
      done      <= (state_nxt == ST_DONE);
      // load stays up one extra cycle past reset release
      load      <= load_hold;
      load_hold <= 1'b0;
      if (state == ST_RUN)
        presc <= (presc == PW'(TICK_DIV - 1)) ? '0 : presc + PW'(1);
    end
  end

endmodule
